dq_rd_gather: RTL

- Downstream of the per-bit DDR3 read ISERDES stage.
- Runs in the oclk_div domain and takes the 4-bit nibbles from one DQ byte lane, one nibble per DQ bit per cycle.
- Applies a per-bit sample alignment, then assembles each burst-of-8 read into one wide word.
- Words are issued by read-command timing (rd_start + rd_lat) and buffered in a small FWFT FIFO for the read-data consumer.

---
 rtl/dq_rd_gather_pkg.sv | 13 +
 rtl/fifo_fwft_sync.sv | 72 +++++++
 rtl/dq_rd_gather.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dq_rd_gather_pkg.sv
// Shared DDR3 PHY constants and the beat/bit index mapping used by the
// read gatherer and the write-side packer.
package dq_rd_gather_pkg;

   localparam int BURST_LEN = 8;
   localparam int NIBBLE    = 4;

   // Position of DQ bit dq_bit of beat number beat inside an assembled burst word.
   function automatic int beat_bit_idx(input int beat, input int dq_bit, input int dq_width);
      return beat * dq_width + dq_bit;
   endfunction

endpackage

// File: rtl/fifo_fwft_sync.sv
// Synchronous first-word-fall-through FIFO with a registered head output that
// holds its last value while empty.
module fifo_fwft_sync #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid,
   output logic             full,
   output logic             wr_accept
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic [WIDTH-1:0] head_r;
   logic             pop_s;
   logic             push_s;
   logic [AW-1:0]    head_nxt_s;
   logic [AW:0]      count_nxt_s;

   // Pop/push qualification; a push at full is accepted only alongside a pop.
   always_comb begin
      pop_s       = rd_en && (count_r != '0);
      full        = (count_r == (AW+1)'(DEPTH));
      push_s      = wr_en && (!full || pop_s);
      head_nxt_s  = pop_s ? (rd_ptr_r + {{(AW-1){1'b0}}, 1'b1}) : rd_ptr_r;
      count_nxt_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
   end

   assign valid     = (count_r != '0);
   assign rd_data   = head_r;
   assign wr_accept = push_s;

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Pointers, occupancy and head register; the head bypasses the array when
   // the slot becoming visible is written in this same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         head_r   <= '0;
      end else begin
         wr_ptr_r <= push_s ? (wr_ptr_r + {{(AW-1){1'b0}}, 1'b1}) : wr_ptr_r;
         rd_ptr_r <= head_nxt_s;
         count_r  <= count_nxt_s;
         if ((count_nxt_s != '0) && (pop_s || (count_r == '0))) begin
            head_r <= (push_s && (wr_ptr_r == head_nxt_s)) ? wr_data : mem_r[head_nxt_s];
         end else begin
            head_r <= head_r;
         end
      end
   end

endmodule

// File: rtl/dq_rd_gather.sv
// Per-byte-lane DDR3 read gatherer: aligns ISERDES nibbles per DQ bit, builds
// burst-of-8 words on read-command timing and queues them in an FWFT FIFO.
module dq_rd_gather
   import dq_rd_gather_pkg::*;
#(
   parameter int DQ_WIDTH   = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int LAT_BITS   = 5
) (
   input  logic                          oclk_div,
   input  logic                          rst_n,
   input  logic [NIBBLE*DQ_WIDTH-1:0]    din,
   input  logic [2*DQ_WIDTH-1:0]         shift,
   input  logic [LAT_BITS-1:0]           rd_lat,
   input  logic                          rd_start,
   output logic [BURST_LEN*DQ_WIDTH-1:0] dout,
   output logic                          dout_valid,
   input  logic                          dout_ready,
   output logic                          busy,
   output logic                          overflow,
   output logic                          collision,
   input  logic                          clr_err
);

   // Pending-burst line: bit 0 marks the push cycle (T+2); two extra slots
   // past 2^LAT_BITS cover the +2 offset and the collision look-ahead.
   localparam int PW = (2 ** LAT_BITS) + 2;
   localparam int WW = BURST_LEN * DQ_WIDTH;

   logic [NIBBLE*DQ_WIDTH-1:0] cur_q_r;
   logic [NIBBLE*DQ_WIDTH-1:0] prev_q_r;
   logic [PW-1:0]              pend_r;
   logic                       busy_r;
   logic                       overflow_r;
   logic                       collision_r;

   logic [LAT_BITS-1:0]        lat_eff_s;
   logic [LAT_BITS:0]          slot_s;
   logic [PW-1:0]              pend_shift_s;
   logic [PW-1:0]              pend_nxt_s;
   logic                       clash_s;
   logic                       accept_s;
   logic                       push_s;
   logic                       drop_s;
   logic                       fifo_full_s;
   logic                       fifo_wr_ok_s;
   logic [WW-1:0]              word_s;
   logic [7:0]                 w_lo_s;
   logic [7:0]                 w_hi_s;
   logic [3:0]                 a_lo_s;
   logic [3:0]                 a_hi_s;
   logic [1:0]                 sh_s;

   // Start scheduling: a new burst clashes if its push slot is within one
   // cycle of an already pending burst.
   always_comb begin
      lat_eff_s    = (rd_lat == '0) ? {{(LAT_BITS-1){1'b0}}, 1'b1} : rd_lat;
      slot_s       = {1'b0, lat_eff_s} + {{LAT_BITS{1'b0}}, 1'b1};
      pend_shift_s = pend_r >> 1;
      clash_s      = pend_shift_s[slot_s - {{LAT_BITS{1'b0}}, 1'b1}] |
                     pend_shift_s[slot_s] |
                     pend_shift_s[slot_s + {{LAT_BITS{1'b0}}, 1'b1}];
      accept_s     = rd_start && !clash_s;
      pend_nxt_s   = pend_shift_s;
      if (accept_s) begin
         pend_nxt_s[slot_s] = 1'b1;
      end else begin
         pend_nxt_s = pend_shift_s;
      end
      push_s = pend_r[0];
      drop_s = push_s && !fifo_wr_ok_s;
   end

   // Word assembly in the push cycle T+2: beats 0..3 come from {din(T+1), din(T)},
   // beats 4..7 from {din(T+2), din(T+1)}, both offset by the per-bit shift.
   always_comb begin
      word_s = '0;
      w_lo_s = 8'h00;
      w_hi_s = 8'h00;
      a_lo_s = 4'h0;
      a_hi_s = 4'h0;
      sh_s   = 2'b00;
      for (int j = 0; j < DQ_WIDTH; j++) begin
         sh_s   = shift[2*j +: 2];
         w_lo_s = {cur_q_r[NIBBLE*j +: NIBBLE], prev_q_r[NIBBLE*j +: NIBBLE]};
         w_hi_s = {din[NIBBLE*j +: NIBBLE], cur_q_r[NIBBLE*j +: NIBBLE]};
         a_lo_s = w_lo_s[sh_s +: 4];
         a_hi_s = w_hi_s[sh_s +: 4];
         for (int k = 0; k < NIBBLE; k++) begin
            word_s[beat_bit_idx(k, j, DQ_WIDTH)]          = a_lo_s[k];
            word_s[beat_bit_idx(k + NIBBLE, j, DQ_WIDTH)] = a_hi_s[k];
         end
      end
   end

   // Input history, pending line, busy and sticky error flags (set beats clear).
   always_ff @(posedge oclk_div or negedge rst_n) begin
      if (!rst_n) begin
         cur_q_r     <= '0;
         prev_q_r    <= '0;
         pend_r      <= '0;
         busy_r      <= 1'b0;
         overflow_r  <= 1'b0;
         collision_r <= 1'b0;
      end else begin
         cur_q_r  <= din;
         prev_q_r <= cur_q_r;
         pend_r   <= pend_nxt_s;
         busy_r   <= |pend_nxt_s;
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (clr_err) begin
            overflow_r <= 1'b0;
         end else begin
            overflow_r <= overflow_r;
         end
         if (rd_start && clash_s) begin
            collision_r <= 1'b1;
         end else if (clr_err) begin
            collision_r <= 1'b0;
         end else begin
            collision_r <= collision_r;
         end
      end
   end

   assign busy      = busy_r;
   assign overflow  = overflow_r;
   assign collision = collision_r;

   fifo_fwft_sync #(
      .WIDTH (WW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (oclk_div),
      .rst_n     (rst_n),
      .wr_en     (push_s),
      .wr_data   (word_s),
      .rd_en     (dout_ready),
      .rd_data   (dout),
      .valid     (dout_valid),
      .full      (fifo_full_s),
      .wr_accept (fifo_wr_ok_s)
   );

endmodule
